regfile_port_arbiter: RTL and testbench
=======================================

# regfile_port_arbiter

Two-requester arbiter and sequencer for the 16 x 4-bit register file. It shares the file's read port 1 and write port between the core datapath (requester 0) and the IO/debug loader (requester 1). Each granted access becomes one register-file transaction. The block generates the file's phase code and write-enable so that writes commit only in the execute phase. It sits between the requesters and the register file; the ALU result path is not routed through it.

## Interface
Parameters:
- EXEC_CODE, 4'b1110: phase code driven on rf_pst during a write issue cycle.
- IDLE_CODE, 4'b0000: phase code driven on rf_pst at all other times.
- PRIO_RESET, 0: requester favoured by the round-robin pointer after reset.

Ports (reset rst, asynchronous, active-high; clock clk):
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- req0 / req1  in  1  access request; held until gnt
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high
- addr0 / addr1  in  4  register address
- wdata0 / wdata1  in  4  write data
- gnt0 / gnt1  out  1  one-cycle grant pulse; the request fields are consumed in this cycle
- done0 / done1  out  1  one-cycle completion pulse
- rdata  out  4  read data; valid only with the done of a read
- err  out  1  pulses with done when the request was a write to address 0
- lock1  in  1  burst lock for requester 1 (see Configuration)
- rf_rd1  out  4  register-file read address 1
- rf_wr  out  4  register-file write address
- rf_wdata  out  4  register-file write data
- rf_reg_write  out  1  register-file write permit
- rf_pst  out  4  register-file phase code
- rf_rdata  in  4  register-file Read_data1

## Operation
- FSM states are S_IDLE, S_ISSUE and S_RESP. Transitions:
  - S_IDLE -> S_ISSUE when any request is eligible.
  - S_ISSUE -> S_RESP unconditionally.
  - S_RESP -> S_IDLE unconditionally.
- Arbitration is evaluated only in S_IDLE:
  - If exactly one requester asserts req, it wins.
  - If both assert req, the requester named by the rr pointer wins.
  - rr is set to the non-winner at the transition to S_ISSUE.
- The winner's fields are latched on entry to S_ISSUE. The latched fields drive:
  - rf_rd1 = addr
  - rf_wr = addr
  - rf_wdata = wdata
- A write with addr != 0 drives rf_reg_write = 1 and rf_pst = EXEC_CODE in S_ISSUE.
- Reads, and writes to address 0, hold rf_reg_write = 0 and rf_pst = IDLE_CODE.
- In S_ISSUE, gnt of the winner is 1.
- In S_RESP:
  - done of the winner is 1.
  - rdata = rf_rdata for reads; rdata = 0 for writes.
  - err = 1 only for a write to address 0.
- A requester deasserts req (or presents a new request) after seeing gnt. A req that is still high in S_RESP is treated as a new request at the next S_IDLE.
- Reset values:
  - gnt0/1, done0/1, err, rf_reg_write = 0
  - rdata, rf_rd1, rf_wr, rf_wdata = 0
  - rf_pst = IDLE_CODE
  - rr = PRIO_RESET
  - state = S_IDLE
- Reset asserted mid-transaction returns the block to S_IDLE immediately. No done is issued for the aborted access, and rf_reg_write drops asynchronously.

## Timing
- Request seen in S_IDLE at cycle T: gnt at T+1, done/rdata at T+2. The earliest next grant is at T+4.
- The register file samples rf_rd1 at the edge ending S_ISSUE; its registered output is valid in S_RESP.
- The write commits at the edge ending S_ISSUE.
- Read-after-write to the same address returns the new value because of the 3-cycle spacing.
- Under continuous contention, grants alternate 0,1,0,1. Worst-case wait is 6 cycles from req to gnt (without lock).
- No combinational path from req*/we*/addr*/wdata* to any output. All outputs are registered or decoded from state plus latched fields.

## Configuration
- RFARB_LOCK_EN defined: lock1 is honoured.
  - If lock1 is high when requester 1 is granted, subsequent S_IDLE arbitration considers only req1 while lock1 remains high.
  - req0 waits.
  - rr is not updated during the locked burst.
  - Lock releases in the first S_IDLE where lock1 = 0.
- RFARB_LOCK_EN undefined: lock1 is ignored (input kept, unused); pure round-robin applies.

## Test plan
- Reset, then req0 read addr 5 (file holds 5) -> gnt0 at T+1, done0 at T+2, rdata = 4'd5, err = 0.
- req1 write addr 7, data 4'hA, then req1 read addr 7 -> rf_reg_write = 1 and rf_pst = 4'b1110 only in the write S_ISSUE cycle; the read returns 4'hA.
- req0 write addr 0, data 4'hF -> rf_reg_write stays 0, done0 and err pulse together, and a later read of addr 0 returns 0.
- Both req held continuously from reset (PRIO_RESET = 0) -> grant order 0,1,0,1 with a 3-cycle period and never two consecutive grants to the same requester.
- With RFARB_LOCK_EN, lock1 = 1 and both req high -> three consecutive grants to requester 1. Drop lock1 -> the next grant goes to requester 0. Without the macro, the same stimulus alternates.
- Assert rst during S_ISSUE of a write to addr 3 -> no done, rf_reg_write low immediately, and addr 3 keeps its prior value.

Source files
------------

// File: rtl/regfile_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// regfile_port_arbiter : two-requester round-robin arbiter and sequencer
// for the 16x4 register file (read port 1 + write port).
// Optional macro RFARB_LOCK_EN enables the requester-1 burst lock.
// Revision: 1.0
// ============================================================================
module regfile_port_arbiter #(
    parameter logic [3:0] EXEC_CODE  = 4'b1110,
    parameter logic [3:0] IDLE_CODE  = 4'b0000,
    parameter logic       PRIO_RESET = 1'b0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic       we0,
    input  logic       we1,
    input  logic [3:0] addr0,
    input  logic [3:0] addr1,
    input  logic [3:0] wdata0,
    input  logic [3:0] wdata1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic [3:0] rdata,
    output logic       err,
    input  logic       lock1,
    output logic [3:0] rf_rd1,
    output logic [3:0] rf_wr,
    output logic [3:0] rf_wdata,
    output logic       rf_reg_write,
    output logic [3:0] rf_pst,
    input  logic [3:0] rf_rdata
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_RESP  = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       rr_q, rr_d;
    logic       sel_q, sel_d;
    logic       we_q, we_d;
    logic [3:0] addr_q, addr_d;
    logic [3:0] wdata_q, wdata_d;
    logic       locked;
    logic       elig0, elig1, win;
    logic       wr_commit;

`ifdef RFARB_LOCK_EN
    logic lock_q, lock_d;

    assign locked = lock_q & lock1;

    // Lock arms on a requester-1 grant and releases in the first idle without lock1.
    always_comb begin
        lock_d = lock_q;
        if (state_q == S_IDLE && !lock1) begin
            lock_d = 1'b0;
        end else if (state_q == S_ISSUE && sel_q && lock1) begin
            lock_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lock_q <= 1'b0;
        end else begin
            lock_q <= lock_d;
        end
    end
`else
    logic lock1_unused;

    assign locked       = 1'b0;
    assign lock1_unused = lock1;
`endif

    assign elig0 = req0 & ~locked;
    assign elig1 = req1;
    // win = 1 selects requester 1; the rr pointer only breaks ties.
    assign win   = elig1 & (~elig0 | rr_q);

    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        sel_d   = sel_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE: begin
                if (elig0 | elig1) begin
                    state_d = S_ISSUE;
                    sel_d   = win;
                    we_d    = win ? we1    : we0;
                    addr_d  = win ? addr1  : addr0;
                    wdata_d = win ? wdata1 : wdata0;
                    if (!locked) begin
                        rr_d = ~win;
                    end
                end
            end
            S_ISSUE: state_d = S_RESP;
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rr_q    <= PRIO_RESET;
            sel_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= 4'd0;
            wdata_q <= 4'd0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            sel_q   <= sel_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
        end
    end

    // Address 0 is hard-wired in the file, so writes to it are never committed.
    assign wr_commit    = (state_q == S_ISSUE) & we_q & (addr_q != 4'd0);

    assign gnt0         = (state_q == S_ISSUE) & ~sel_q;
    assign gnt1         = (state_q == S_ISSUE) &  sel_q;
    assign done0        = (state_q == S_RESP)  & ~sel_q;
    assign done1        = (state_q == S_RESP)  &  sel_q;
    assign err          = (state_q == S_RESP)  & we_q & (addr_q == 4'd0);
    assign rdata        = ((state_q == S_RESP) && !we_q) ? rf_rdata : 4'd0;
    assign rf_rd1       = addr_q;
    assign rf_wr        = addr_q;
    assign rf_wdata     = wdata_q;
    assign rf_reg_write = wr_commit;
    assign rf_pst       = wr_commit ? EXEC_CODE : IDLE_CODE;

endmodule
`default_nettype wire

// File: tb/tb_regfile_port_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// tb_regfile_port_arbiter : directed self-checking bench with a 16x4
// register-file model behind the arbiter.  Revision: 1.0
// ============================================================================
module tb_regfile_port_arbiter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       req0 = 1'b0, req1 = 1'b0, we0 = 1'b0, we1 = 1'b0, lock1 = 1'b0;
    logic [3:0] addr0 = 4'd0, addr1 = 4'd0, wdata0 = 4'd0, wdata1 = 4'd0;
    logic       gnt0, gnt1, done0, done1, err, rf_reg_write;
    logic [3:0] rdata, rf_rd1, rf_wr, rf_wdata, rf_pst;
    logic [3:0] rf_rdata = 4'd0;
    logic [3:0] mem [16];

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    regfile_port_arbiter dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1), .we0(we0), .we1(we1),
        .addr0(addr0), .addr1(addr1), .wdata0(wdata0), .wdata1(wdata1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .rdata(rdata), .err(err), .lock1(lock1),
        .rf_rd1(rf_rd1), .rf_wr(rf_wr), .rf_wdata(rf_wdata),
        .rf_reg_write(rf_reg_write), .rf_pst(rf_pst), .rf_rdata(rf_rdata)
    );

    // Register file: registered read, write only in the execute phase.
    initial begin
        for (int i = 0; i < 16; i++) mem[i] = i[3:0];
    end
    always @(posedge clk) begin
        if (rf_reg_write && rf_pst == 4'b1110) mem[rf_wr] <= rf_wdata;
        rf_rdata <= mem[rf_rd1];
    end

    task automatic check_val(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic reset_dut();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // One isolated transaction with cycle-exact checks, starting from idle.
    task automatic txn(input string tag, input logic id, input logic we, input logic [3:0] a,
                       input logic [3:0] d, input logic [3:0] exp_rdata, input logic exp_err);
        logic       exp_wr;
        logic [1:0] exp_g;
        exp_wr = we && (a != 4'd0);
        exp_g  = id ? 2'b01 : 2'b10;
        @(posedge clk); #1;
        if (id) begin req1 = 1'b1; we1 = we; addr1 = a; wdata1 = d; end
        else    begin req0 = 1'b1; we0 = we; addr0 = a; wdata0 = d; end
        check_val({tag, "_gnt_T"}, {gnt0, gnt1}, 2'b00);
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        check_val({tag, "_gnt"}, {gnt0, gnt1}, exp_g);
        check_val({tag, "_wr_issue"}, {rf_reg_write, rf_pst, rf_wr}, {exp_wr, exp_wr ? 4'b1110 : 4'b0000, a});
        @(posedge clk); #1;
        check_val({tag, "_done"}, {done0, done1}, exp_g);
        check_val({tag, "_rdata_err"}, {rdata, err}, {exp_rdata, exp_err});
        check_val({tag, "_wr_resp"}, {rf_reg_write, rf_pst}, 5'd0);
        @(posedge clk); #1;
        check_val({tag, "_idle"}, {gnt0, gnt1, done0, done1, err}, 5'd0);
    endtask

    initial begin
        logic [1:0] exp_g;

        @(negedge clk);
        check_val("rst_ctrl", {gnt0, gnt1, done0, done1, err, rf_reg_write}, 6'd0);
        check_val("rst_data", {rdata, rf_rd1, rf_wr, rf_wdata, rf_pst}, 20'd0);
        reset_dut();

        txn("rd5",   1'b0, 1'b0, 4'd5, 4'h0, 4'd5, 1'b0);
        txn("wr7",   1'b1, 1'b1, 4'd7, 4'hA, 4'd0, 1'b0);
        txn("rd7",   1'b1, 1'b0, 4'd7, 4'h0, 4'hA, 1'b0);
        txn("wr0",   1'b0, 1'b1, 4'd0, 4'hF, 4'd0, 1'b1);
        txn("rd0",   1'b0, 1'b0, 4'd0, 4'h0, 4'd0, 1'b0);

        // Continuous contention from reset: 0,1,0,1 every 3 cycles.
        reset_dut();
        req0 = 1'b1; we0 = 1'b0; addr0 = 4'd1;
        req1 = 1'b1; we1 = 1'b0; addr1 = 4'd2;
        for (int k = 1; k <= 12; k++) begin
            @(posedge clk); #1;
            check_val($sformatf("rr_k%0d", k), {gnt0, gnt1}, {k % 6 == 1, k % 6 == 4});
        end
        req0 = 1'b0; req1 = 1'b0;

        // Burst lock on requester 1; released by dropping lock1.
        reset_dut();
        lock1 = 1'b1;
        req0 = 1'b1; req1 = 1'b1;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clk); #1;
`ifdef RFARB_LOCK_EN
            exp_g = (k == 1 || k == 13) ? 2'b10 : (k == 4 || k == 7 || k == 10) ? 2'b01 : 2'b00;
`else
            exp_g = (k == 1 || k == 7 || k == 13) ? 2'b10 : (k == 4 || k == 10) ? 2'b01 : 2'b00;
`endif
            check_val($sformatf("lock_k%0d", k), {gnt0, gnt1}, exp_g);
            if (k == 11) lock1 = 1'b0;
        end
        req0 = 1'b0; req1 = 1'b0;

        // Reset in the issue cycle of a write to addr 3.
        reset_dut();
        @(posedge clk); #1;
        req0 = 1'b1; we0 = 1'b1; addr0 = 4'd3; wdata0 = 4'hC;
        @(posedge clk); #1;
        req0 = 1'b0;
        check_val("abort_issue", {gnt0, rf_reg_write}, 2'b11);
        #2 rst = 1'b1;
        #1 check_val("abort_async", {gnt0, rf_reg_write, rf_pst}, 6'd0);
        @(posedge clk); #1;
        check_val("abort_nodone0", {done0, done1}, 2'b00);
        rst = 1'b0;
        @(posedge clk); #1;
        check_val("abort_nodone1", {gnt0, gnt1, done0, done1}, 4'd0);
        txn("rd3", 1'b0, 1'b0, 4'd3, 4'h0, 4'd3, 1'b0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
